sync_timing_gen: RTL and testbench

Parametrised successor to the LCD sync pulse generator. Produces hSync/vSync, horizontal/vertical data enables, the combined data enable, and pixel coordinates for a panel whose porch, sync and active widths and sync polarities are set by parameters. Adds an enable control, a programmable count of blanked start-up frames, frame and line start strobes, and a parametrised user-input tick. Sits between the pixel clock and the pixel/character renderer.

---
 rtl/video_timing_pkg.sv | 33 +++
 rtl/tick_divider.sv | 42 ++++
 rtl/sync_timing_gen.sv | 153 +++++++++++++++
 tb/tb_sync_timing_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the panel timing blocks: default 480x272
// geometry, total-length derivation, bit-width helper and FSM state codes.
package video_timing_pkg;

  localparam int DEF_H_SYNC   = 41;
  localparam int DEF_H_BACK   = 2;
  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FRONT  = 2;
  localparam int DEF_V_SYNC   = 10;
  localparam int DEF_V_BACK   = 2;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FRONT  = 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  function automatic int span(input int sync_w, input int back_w,
                              input int active_w, input int front_w);
    return sync_w + back_w + active_w + front_w;
  endfunction

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int result = 0;
    for (int n = value - 1; n > 0; n = n >> 1) result++;
    return (result < 1) ? 1 : result;
  endfunction

  localparam int DEF_H_TOTAL = span(DEF_H_SYNC, DEF_H_BACK, DEF_H_ACTIVE, DEF_H_FRONT);
  localparam int DEF_V_TOTAL = span(DEF_V_SYNC, DEF_V_BACK, DEF_V_ACTIVE, DEF_V_FRONT);

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: userTick pulses once every TICK_DIV clocks and
// userClk toggles on each tick.
module tick_divider
  import video_timing_pkg::*;
#(
  parameter int TICK_DIV = 1500000
) (
  input  logic clk9MHz,
  input  logic resetN,
  output logic userTick,
  output logic userClk
);

  localparam int CW = clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("tick_divider: TICK_DIV must be at least 1");
  end

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          tick_next;

  always_comb begin
    cnt_next  = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);
    tick_next = (cnt_next == CNT_LAST);
  end

  always_ff @(posedge clk9MHz or negedge resetN) begin
    if (!resetN) begin
      cnt_reg  <= '0;
      userTick <= 1'b0;
      userClk  <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      userTick <= tick_next;
      userClk  <= userClk ^ tick_next;
    end
  end

endmodule

// File: rtl/sync_timing_gen.sv
// Parametrised LCD sync/data-enable generator with blanked start-up frames.
// Outputs are decoded from next-state counters so they line up with the counters.
module sync_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_SYNC       = DEF_H_SYNC,
  parameter int   H_BACK       = DEF_H_BACK,
  parameter int   H_ACTIVE     = DEF_H_ACTIVE,
  parameter int   H_FRONT      = DEF_H_FRONT,
  parameter int   V_SYNC       = DEF_V_SYNC,
  parameter int   V_BACK       = DEF_V_BACK,
  parameter int   V_ACTIVE     = DEF_V_ACTIVE,
  parameter int   V_FRONT      = DEF_V_FRONT,
  parameter logic HS_POL       = 1'b0,
  parameter logic VS_POL       = 1'b0,
  parameter int   START_FRAMES = 10,
  parameter int   TICK_DIV     = 1500000,
  localparam int  H_TOTAL      = span(H_SYNC, H_BACK, H_ACTIVE, H_FRONT),
  localparam int  V_TOTAL      = span(V_SYNC, V_BACK, V_ACTIVE, V_FRONT),
  localparam int  HW           = clog2(H_TOTAL),
  localparam int  VW           = clog2(V_TOTAL)
) (
  input  logic          clk9MHz,
  input  logic          resetN,
  input  logic          enable,
  output logic          hSync,
  output logic          vSync,
  output logic          hData,
  output logic          vData,
  output logic          de,
  output logic [HW-1:0] pixelX,
  output logic [VW-1:0] pixelY,
  output logic          lineStart,
  output logic          frameStart,
  output logic          startDone,
  output logic          disp,
  output logic          userTick,
  output logic          userClk
);

  localparam int BW = clog2(START_FRAMES + 1);

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_START = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT_END   = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_START = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_END   = VW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [BW-1:0] BLANK_LAST  = BW'(START_FRAMES);

  if (H_SYNC < 1 || H_BACK < 1 || H_ACTIVE < 1 || H_FRONT < 1 ||
      V_SYNC < 1 || V_BACK < 1 || V_ACTIVE < 1 || V_FRONT < 1 ||
      START_FRAMES < 0 || TICK_DIV < 1) begin : g_bad_param
    $error("sync_timing_gen: timing parameters must be >= 1, START_FRAMES >= 0");
  end
  if (H_TOTAL - 1 >= (1 << HW) || V_TOTAL - 1 >= (1 << VW)) begin : g_bad_width
    $error("sync_timing_gen: line or frame total does not fit counter width");
  end

  logic [1:0]    state_reg, state_next;
  logic [HW-1:0] h_count_reg, h_count_next;
  logic [VW-1:0] v_count_reg, v_count_next;
  logic [BW-1:0] blank_count_reg, blank_count_next;

  // Mid-frame enable drop is abrupt: everything returns to the idle origin.
  always_comb begin
    state_next       = state_reg;
    h_count_next     = h_count_reg;
    v_count_next     = v_count_reg;
    blank_count_next = blank_count_reg;
    if (state_reg == IDLE) begin
      h_count_next     = '0;
      v_count_next     = '0;
      blank_count_next = '0;
      if (enable) state_next = (START_FRAMES == 0) ? RUN : BLANK;
    end else if (!enable) begin
      state_next       = IDLE;
      h_count_next     = '0;
      v_count_next     = '0;
      blank_count_next = '0;
    end else if (h_count_reg != H_LAST) begin
      h_count_next = h_count_reg + HW'(1);
    end else begin
      h_count_next = '0;
      if (v_count_reg != V_LAST) begin
        v_count_next = v_count_reg + VW'(1);
      end else begin
        v_count_next = '0;
        if (state_reg == BLANK) begin
          blank_count_next = blank_count_reg + BW'(1);
          if (blank_count_reg + BW'(1) == BLANK_LAST) state_next = RUN;
        end
      end
    end
  end

  logic running_next, h_data_next, v_data_next, start_done_next;

  always_comb begin
    running_next    = (state_next != IDLE);
    start_done_next = (state_next == RUN);
    h_data_next     = running_next && (h_count_next >= H_ACT_START) && (h_count_next < H_ACT_END);
    v_data_next     = running_next && (v_count_next >= V_ACT_START) && (v_count_next < V_ACT_END);
  end

  always_ff @(posedge clk9MHz or negedge resetN) begin
    if (!resetN) begin
      state_reg       <= IDLE;
      h_count_reg     <= '0;
      v_count_reg     <= '0;
      blank_count_reg <= '0;
      hSync           <= ~HS_POL;
      vSync           <= ~VS_POL;
      hData           <= 1'b0;
      vData           <= 1'b0;
      de              <= 1'b0;
      pixelX          <= '0;
      pixelY          <= '0;
      lineStart       <= 1'b0;
      frameStart      <= 1'b0;
      startDone       <= 1'b0;
      disp            <= 1'b0;
    end else begin
      state_reg       <= state_next;
      h_count_reg     <= h_count_next;
      v_count_reg     <= v_count_next;
      blank_count_reg <= blank_count_next;
      hSync           <= (running_next && h_count_next < H_SYNC_END) ? HS_POL : ~HS_POL;
      vSync           <= (running_next && v_count_next < V_SYNC_END) ? VS_POL : ~VS_POL;
      hData           <= h_data_next;
      vData           <= v_data_next;
      de              <= h_data_next && v_data_next && start_done_next;
      pixelX          <= h_data_next ? h_count_next - H_ACT_START : '0;
      pixelY          <= v_data_next ? v_count_next - V_ACT_START : '0;
      lineStart       <= running_next && (h_count_next == '0);
      frameStart      <= running_next && (h_count_next == '0) && (v_count_next == '0);
      startDone       <= start_done_next;
      disp            <= running_next;
    end
  end

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk9MHz  (clk9MHz),
    .resetN   (resetN),
    .userTick (userTick),
    .userClk  (userClk)
  );

endmodule

// File: tb/tb_sync_timing_gen.sv
// Bench for sync_timing_gen: two small-geometry instances (no blank frames /
// two blank frames, opposite sync polarities) checked against a cycle-index model.
module tb_sync_timing_gen;

  localparam int HS = 2, HB = 1, HA = 4, HF = 1;
  localparam int VS = 1, VB = 1, VA = 3, VF = 1;
  localparam int HT = HS + HB + HA + HF;  // 8
  localparam int VT = VS + VB + VA + VF;  // 6
  localparam int FT = HT * VT;            // 48
  localparam int TD = 5;

  typedef struct packed {
    logic       hs, vs, hd, vd, de;
    logic [2:0] px, py;
    logic       ls, fs, sd, disp, tick, uclk;
  } obs_t;

  logic clk9MHz = 1'b0;
  logic resetN, enable;
  always #5 clk9MHz = ~clk9MHz;

  logic       a_hSync, a_vSync, a_hData, a_vData, a_de, a_lineStart, a_frameStart;
  logic       a_startDone, a_disp, a_userTick, a_userClk;
  logic [2:0] a_pixelX, a_pixelY;
  logic       b_hSync, b_vSync, b_hData, b_vData, b_de, b_lineStart, b_frameStart;
  logic       b_startDone, b_disp, b_userTick, b_userClk;
  logic [2:0] b_pixelX, b_pixelY;

  sync_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .HS_POL(1'b0), .VS_POL(1'b0), .START_FRAMES(0), .TICK_DIV(TD)
  ) dut_a (
    .clk9MHz(clk9MHz), .resetN(resetN), .enable(enable),
    .hSync(a_hSync), .vSync(a_vSync), .hData(a_hData), .vData(a_vData), .de(a_de),
    .pixelX(a_pixelX), .pixelY(a_pixelY), .lineStart(a_lineStart), .frameStart(a_frameStart),
    .startDone(a_startDone), .disp(a_disp), .userTick(a_userTick), .userClk(a_userClk)
  );

  sync_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .HS_POL(1'b1), .VS_POL(1'b1), .START_FRAMES(2), .TICK_DIV(TD)
  ) dut_b (
    .clk9MHz(clk9MHz), .resetN(resetN), .enable(enable),
    .hSync(b_hSync), .vSync(b_vSync), .hData(b_hData), .vData(b_vData), .de(b_de),
    .pixelX(b_pixelX), .pixelY(b_pixelY), .lineStart(b_lineStart), .frameStart(b_frameStart),
    .startDone(b_startDone), .disp(b_disp), .userTick(b_userTick), .userClk(b_userClk)
  );

  obs_t a_obs, b_obs;
  assign a_obs = {a_hSync, a_vSync, a_hData, a_vData, a_de, a_pixelX, a_pixelY,
                  a_lineStart, a_frameStart, a_startDone, a_disp, a_userTick, a_userClk};
  assign b_obs = {b_hSync, b_vSync, b_hData, b_vData, b_de, b_pixelX, b_pixelY,
                  b_lineStart, b_frameStart, b_startDone, b_disp, b_userTick, b_userClk};

  // Model: m_t = cycles since the timing was started, m_k = clocks since reset release.
  bit m_run;
  int m_t, m_k;
  always @(posedge clk9MHz or negedge resetN) begin
    if (!resetN) begin
      m_run <= 1'b0;
      m_t   <= 0;
      m_k   <= 0;
    end else begin
      m_k <= m_k + 1;
      if (!m_run) begin
        if (enable) begin
          m_run <= 1'b1;
          m_t   <= 0;
        end
      end else if (!enable) begin
        m_run <= 1'b0;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  function automatic obs_t expect_obs(bit run, int t, int k, int sf, bit hp, bit vp);
    obs_t e;
    int h, v;
    e      = '0;
    e.hs   = !hp;
    e.vs   = !vp;
    e.tick = ((k % TD) == TD - 1);
    e.uclk = ((((k + 1) / TD) % 2) == 1);
    if (run) begin
      h      = t % HT;
      v      = (t / HT) % VT;
      e.sd   = ((t / FT) >= sf);
      e.hs   = (h < HS) ? hp : !hp;
      e.vs   = (v < VS) ? vp : !vp;
      e.hd   = (h >= HS + HB) && (h < HS + HB + HA);
      e.vd   = (v >= VS + VB) && (v < VS + VB + VA);
      e.de   = e.hd && e.vd && e.sd;
      e.px   = e.hd ? 3'(h - (HS + HB)) : 3'd0;
      e.py   = e.vd ? 3'(v - (VS + VB)) : 3'd0;
      e.ls   = (h == 0);
      e.fs   = (h == 0) && (v == 0);
      e.disp = 1'b1;
    end
    return e;
  endfunction

  int checks = 0;
  int fails  = 0;

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL model_%s run=%0d t=%0d k=%0d got=%05h want=%05h",
               name, m_run, m_t, m_k, act, exp);
    end
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end else begin
      $display("check %s = %0d", name, act);
    end
  endtask

  always @(negedge clk9MHz) begin
    check_obs("a", a_obs, expect_obs(m_run, m_t, m_k, 0, 1'b0, 1'b0));
    check_obs("b", b_obs, expect_obs(m_run, m_t, m_k, 2, 1'b1, 1'b1));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk9MHz);
    #1;
  endtask

  initial begin
    resetN = 1'b0;
    enable = 1'b1;
    step(3);
    check_lit("rst_a_hSync", a_hSync, 1);
    check_lit("rst_a_vSync", a_vSync, 1);
    check_lit("rst_a_de", a_de, 0);
    check_lit("rst_a_disp", a_disp, 0);
    check_lit("rst_a_pixelX", a_pixelX, 0);
    check_lit("rst_a_userClk", a_userClk, 0);
    check_lit("rst_b_hSync", b_hSync, 0);

    @(negedge clk9MHz);
    #2 resetN = 1'b1;
    step(1);  // t=0
    check_lit("start_a_disp", a_disp, 1);
    check_lit("start_b_disp", b_disp, 1);
    check_lit("start_a_frameStart", a_frameStart, 1);
    check_lit("start_a_lineStart", a_lineStart, 1);
    check_lit("start_a_hSync", a_hSync, 0);
    check_lit("start_b_hSync", b_hSync, 1);
    check_lit("start_a_startDone", a_startDone, 1);
    check_lit("start_b_startDone", b_startDone, 0);
    step(3);  // t=3, 4 clocks after release
    check_lit("t3_a_hData", a_hData, 1);
    check_lit("t3_a_pixelX", a_pixelX, 0);
    check_lit("t3_a_userTick", a_userTick, 1);
    check_lit("t3_a_userClk", a_userClk, 1);
    step(3);  // t=6
    check_lit("t6_a_pixelX", a_pixelX, 3);
    step(1);  // t=7
    check_lit("t7_a_hData", a_hData, 0);
    step(1);  // t=8: line 1
    check_lit("t8_a_lineStart", a_lineStart, 1);
    check_lit("t8_a_frameStart", a_frameStart, 0);
    check_lit("t8_a_vSync", a_vSync, 1);
    step(14); // t=22: v=2 h=6
    check_lit("t22_a_de", a_de, 1);
    check_lit("t22_a_pixelX", a_pixelX, 3);
    check_lit("t22_b_de", b_de, 0);
    step(26); // t=48: second frame
    check_lit("t48_a_frameStart", a_frameStart, 1);
    check_lit("t48_a_vSync", a_vSync, 0);
    check_lit("t48_b_vSync", b_vSync, 1);
    step(47); // t=95
    check_lit("t95_b_startDone", b_startDone, 0);
    step(1);  // t=96: third frame
    check_lit("t96_b_startDone", b_startDone, 1);
    check_lit("t96_b_frameStart", b_frameStart, 1);
    step(18); // t=114: v=2 h=2
    check_lit("t114_b_de", b_de, 0);
    step(1);  // t=115: v=2 h=3
    check_lit("t115_b_de", b_de, 1);
    check_lit("t115_b_pixelY", b_pixelY, 0);
    step(2);  // t=117: v=2 h=5
    check_lit("t117_b_pixelX", b_pixelX, 2);
    enable = 1'b0;
    step(1);
    check_lit("drop_b_startDone", b_startDone, 0);
    check_lit("drop_b_disp", b_disp, 0);
    check_lit("drop_a_disp", a_disp, 0);
    check_lit("drop_a_hSync", a_hSync, 1);
    check_lit("drop_b_hSync", b_hSync, 0);
    check_lit("drop_a_lineStart", a_lineStart, 0);
    step(3);
    enable = 1'b1;
    step(1);  // restart, t=0
    check_lit("re_b_startDone", b_startDone, 0);
    check_lit("re_b_disp", b_disp, 1);
    step(96);
    check_lit("re96_b_startDone", b_startDone, 1);
    step(20); // mid-line, then async reset between edges
    #2 resetN = 1'b0;
    #1;
    check_lit("arst_a_hSync", a_hSync, 1);
    check_lit("arst_a_disp", a_disp, 0);
    check_lit("arst_a_userTick", a_userTick, 0);
    check_lit("arst_a_userClk", a_userClk, 0);
    check_lit("arst_b_vSync", b_vSync, 0);
    check_lit("arst_b_startDone", b_startDone, 0);
    @(negedge clk9MHz);
    #2 resetN = 1'b1;
    step(10);
    for (int i = 0; i < 4; i++) begin
      enable = 1'b0;
      step(3 + i);
      enable = 1'b1;
      step(11 + 2 * i);
    end
    step(20);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
